// File: rtl/fpu_ss_wb_arb.sv
// Writeback arbiter: merges FPU results and load/store completions into one registered result slot.
// Optional FPU_SS_WB_RR_EN selects two-way round-robin instead of fixed mem-over-FPU priority.
module fpu_ss_wb_arb #(
    parameter int unsigned ID_WIDTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                fpu_valid_i,
    output logic                fpu_ready_o,
    input  logic [31:0]         fpu_result_i,
    input  logic [4:0]          fpu_fflags_i,
    input  logic [4:0]          fpu_addr_i,
    input  logic                fpu_rd_is_fp_i,
    input  logic [ID_WIDTH-1:0] fpu_id_i,

    input  logic                mem_valid_i,
    output logic                mem_ready_o,
    input  logic [31:0]         mem_rdata_i,
    input  logic [4:0]          mem_rd_i,
    input  logic                mem_we_i,
    input  logic [ID_WIDTH-1:0] mem_id_i,

    output logic                fpr_we_o,
    output logic [4:0]          fpr_waddr_o,
    output logic [31:0]         fpr_wdata_o,

    output logic                x_result_valid_o,
    input  logic                x_result_ready_i,
    output logic [ID_WIDTH-1:0] x_result_id_o,
    output logic [31:0]         x_result_data_o,
    output logic [4:0]          x_result_rd_o,
    output logic                x_result_we_o,
    output logic [2:0]          x_result_ecswe_o,
    output logic [5:0]          x_result_ecsdata_o,

    output logic                fflags_valid_o,
    output logic [4:0]          fflags_o
);

    localparam logic [2:0] ECSWE_FS    = 3'b010;
    localparam logic [5:0] ECSDATA_FS  = 6'b001100;

    logic slot_free;
    logic mem_wins;
    logic grant_mem;
    logic grant_fpu;

    assign slot_free = !x_result_valid_o || x_result_ready_i;

`ifdef FPU_SS_WB_RR_EN
    logic prefer_mem_q;

    assign mem_wins = !fpu_valid_i || prefer_mem_q;

    // After every grant the pointer favours whichever source lost out.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prefer_mem_q <= 1'b0;
        end else if (grant_mem) begin
            prefer_mem_q <= 1'b0;
        end else if (grant_fpu) begin
            prefer_mem_q <= 1'b1;
        end
    end
`else
    assign mem_wins = 1'b1;
`endif

    always_comb begin
        grant_mem = !rst_i && slot_free && mem_valid_i && mem_wins;
        grant_fpu = !rst_i && slot_free && fpu_valid_i && !grant_mem;
    end

    assign mem_ready_o = grant_mem;
    assign fpu_ready_o = grant_fpu;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_result_valid_o   <= 1'b0;
            x_result_id_o      <= '0;
            x_result_data_o    <= '0;
            x_result_rd_o      <= '0;
            x_result_we_o      <= 1'b0;
            x_result_ecswe_o   <= '0;
            x_result_ecsdata_o <= '0;
            fpr_we_o           <= 1'b0;
            fpr_waddr_o        <= '0;
            fpr_wdata_o        <= '0;
            fflags_valid_o     <= 1'b0;
            fflags_o           <= '0;
        end else begin
            fpr_we_o       <= 1'b0;
            fflags_valid_o <= 1'b0;
            if (grant_mem) begin
                x_result_valid_o <= 1'b1;
                x_result_id_o    <= mem_id_i;
                x_result_rd_o    <= mem_rd_i;
                x_result_we_o    <= 1'b0;
                if (mem_we_i) begin
                    x_result_data_o    <= mem_rdata_i;
                    x_result_ecswe_o   <= ECSWE_FS;
                    x_result_ecsdata_o <= ECSDATA_FS;
                    fpr_we_o           <= 1'b1;
                    fpr_waddr_o        <= mem_rd_i;
                    fpr_wdata_o        <= mem_rdata_i;
                end else begin
                    x_result_data_o    <= '0;
                    x_result_ecswe_o   <= '0;
                    x_result_ecsdata_o <= '0;
                end
            end else if (grant_fpu) begin
                x_result_valid_o <= 1'b1;
                x_result_id_o    <= fpu_id_i;
                x_result_rd_o    <= fpu_addr_i;
                x_result_data_o  <= fpu_result_i;
                fflags_valid_o   <= 1'b1;
                fflags_o         <= fpu_fflags_i;
                if (fpu_rd_is_fp_i) begin
                    x_result_we_o      <= 1'b0;
                    x_result_ecswe_o   <= ECSWE_FS;
                    x_result_ecsdata_o <= ECSDATA_FS;
                    fpr_we_o           <= 1'b1;
                    fpr_waddr_o        <= fpu_addr_i;
                    fpr_wdata_o        <= fpu_result_i;
                end else begin
                    x_result_we_o      <= 1'b1;
                    x_result_ecswe_o   <= '0;
                    x_result_ecsdata_o <= '0;
                end
            end else if (x_result_ready_i) begin
                x_result_valid_o <= 1'b0;
            end
        end
    end

endmodule
